sha2_msg_schedule: RTL and testbench

Message-schedule producer for the SHA-2 compression datapath. It accepts one 16-word message block over a valid/ready input stream. It then emits the expanded schedule words W0..W(ROUNDS-1) in order over a valid/ready output stream, one word per round, feeding the round logic's Wj operand. It supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds) by parameter.

---
 rtl/sha2_msg_schedule.sv | 174 +++++++++++++++++
 tb/tb_sha2_msg_schedule.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_schedule.sv
// sha2_msg_schedule
//   SHA-2 message-schedule producer. Accepts one 16-word message block on a
//   valid/ready input stream, then emits the expanded schedule words
//   W0..W(ROUNDS-1) in order on a valid/ready output stream, one per round.
//   WORDSIZE=32/ROUNDS=64 gives SHA-256, WORDSIZE=64/ROUNDS=80 gives SHA-512.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   abort      (only with SHA2_SCHED_ABORT_EN) synchronous active-high abort
//   in_valid   in_word valid
//   in_ready   block accepts an input word (LOAD state)
//   in_word    message word, M0 first
//   out_valid  out_word valid (EMIT state)
//   out_ready  round logic consumes out_word
//   out_word   schedule word Wj
//   out_index  j of current out_word
//   out_last   high with out_valid when out_index == ROUNDS-1
//   busy       high in EMIT state
//
// Optional feature macro: SHA2_SCHED_ABORT_EN adds the abort input.

module sha2_msg_schedule #(
    parameter int WORDSIZE = 32,
    parameter int ROUNDS   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef SHA2_SCHED_ABORT_EN
    input  logic                abort,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORDSIZE-1:0] in_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] out_word,
    output logic [6:0]          out_index,
    output logic                out_last,
    output logic                busy
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          load_cnt;
    logic [WORDSIZE-1:0] w [16];
    logic [WORDSIZE-1:0] w_new;
    logic                in_fire;
    logic                out_fire;
    logic                abort_req;

    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    // Only the branch matching WORDSIZE elaborates, so each branch sees
    // window entries of exactly the width its sigma functions expect.
    generate
        if (ROUNDS < 1 || ROUNDS > 128) begin : g_bad_rounds
            $error("sha2_msg_schedule: ROUNDS must fit a 7-bit index");
        end
        if (WORDSIZE == 32) begin : g_w32
            assign w_new = sig1_32(w[14]) + w[9] + sig0_32(w[1]) + w[0];
        end else if (WORDSIZE == 64) begin : g_w64
            assign w_new = sig1_64(w[14]) + w[9] + sig0_64(w[1]) + w[0];
        end else begin : g_bad_wordsize
            $error("sha2_msg_schedule: WORDSIZE must be 32 or 64");
        end
    endgenerate

`ifdef SHA2_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_word = w[0];
    assign out_last = out_valid && (out_index == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides any same-cycle handshake
    always_comb begin
        state_nxt = state;
        if (abort_req) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (in_fire && load_cnt == 4'd15) state_nxt = EMIT;
                EMIT:    if (out_fire && out_last) state_nxt = LOAD;
                default: state_nxt = LOAD;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: in_ready = 1'b1;
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters: load_cnt wraps 15->0 on the 16th accept, so it is already
    // zero when EMIT begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= 4'd0;
            out_index <= 7'd0;
        end else if (abort_req) begin
            load_cnt  <= 4'd0;
            out_index <= 7'd0;
        end else begin
            if (in_fire) begin
                load_cnt <= load_cnt + 4'd1;
            end
            if (out_fire) begin
                out_index <= out_last ? 7'd0 : out_index + 7'd1;
            end
        end
    end

    // Sliding window: the same shift serves both loading and expansion.
    // in_fire and out_fire are mutually exclusive since they live in
    // different states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else if (!abort_req && (in_fire || out_fire)) begin
            for (int i = 0; i < 15; i++) begin
                w[i] <= w[i+1];
            end
            w[15] <= in_fire ? in_word : w_new;
        end
    end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
module tb_sha2_msg_schedule;

    logic        clk;
    logic        rst_n;
    logic        sel;            // 0: SHA-256 instance, 1: SHA-512 instance
    logic        in_valid;
    logic [63:0] in_word;
    logic        out_ready;
    logic        abort;

    logic        in_ready32, out_valid32, out_last32, busy32;
    logic [31:0] out_word32;
    logic [6:0]  out_index32;
    logic        in_ready64, out_valid64, out_last64, busy64;
    logic [63:0] out_word64;
    logic [6:0]  out_index64;

    logic        in_valid32, in_valid64, out_ready32, out_ready64;
    logic        abort32, abort64;

    logic        o_in_ready, o_valid, o_last, o_busy;
    logic [63:0] o_word;
    logic [6:0]  o_index;

    int          checks;
    int          failures;
    int          rounds;
    int          ws;
    logic [63:0] blk [16];
    logic [63:0] expw [80];
    logic [63:0] got  [80];

    assign in_valid32  = in_valid & ~sel;
    assign in_valid64  = in_valid & sel;
    assign out_ready32 = out_ready & ~sel;
    assign out_ready64 = out_ready & sel;
    assign abort32     = abort & ~sel;
    assign abort64     = abort & sel;

    assign o_in_ready = sel ? in_ready64  : in_ready32;
    assign o_valid    = sel ? out_valid64 : out_valid32;
    assign o_last     = sel ? out_last64  : out_last32;
    assign o_busy     = sel ? busy64      : busy32;
    assign o_index    = sel ? out_index64 : out_index32;
    assign o_word     = sel ? out_word64  : {32'h0, out_word32};

    sha2_msg_schedule #(.WORDSIZE(32), .ROUNDS(64)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHA2_SCHED_ABORT_EN
        .abort     (abort32),
`endif
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_word   (in_word[31:0]),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_word  (out_word32),
        .out_index (out_index32),
        .out_last  (out_last32),
        .busy      (busy32)
    );

    sha2_msg_schedule #(.WORDSIZE(64), .ROUNDS(80)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SHA2_SCHED_ABORT_EN
        .abort     (abort64),
`endif
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_word   (in_word),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .out_word  (out_word64),
        .out_index (out_index64),
        .out_last  (out_last64),
        .busy      (busy64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: FIPS 180-4 schedule recurrence over a flat array.
    function automatic logic [63:0] wmask(input int wsz);
        return (wsz == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int wsz);
        return ((x >> n) | (x << (wsz - n))) & wmask(wsz);
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input int wsz);
        if (wsz == 32) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
        return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input int wsz);
        if (wsz == 32) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
        return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    endfunction

    task automatic build_exp();
        for (int t = 0; t < 80; t++) begin
            if (t < 16) expw[t] = blk[t] & wmask(ws);
            else expw[t] = (ssig1(expw[t-2], ws) + expw[t-7] + ssig0(expw[t-15], ws)
                            + expw[t-16]) & wmask(ws);
        end
    endtask

    task automatic select(input logic s);
        sel    = s;
        ws     = s ? 64 : 32;
        rounds = s ? 80 : 64;
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 64'h0;
        blk[0]  = (ws == 32) ? 64'h61626380 : 64'h6162638000000000;
        blk[15] = 64'h18;
        build_exp();
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom} & wmask(ws);
        build_exp();
    endtask

    task automatic load(input bit gaps);
        int idx;
        idx = 0;
        for (int c = 0; c < 500 && idx < 16; c++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            chk("load_in_ready", {63'h0, o_in_ready}, 64'h1);
            chk("load_out_valid", {63'h0, o_valid}, 64'h0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_word  = {$urandom, $urandom};
            end else begin
                in_valid = 1'b1;
                in_word  = blk[idx];
                idx++;
            end
        end
        chk("load_count", 64'(idx), 64'd16);
    endtask

    task automatic drain(input int stall_at, input int stall_len, input bit rnd_ready,
                         input int stop_at);
        int  j;
        int  stall_left;
        bit  done;
        bit  stopped;
        logic rdy;
        j = 0;
        stall_left = stall_len;
        done = 1'b0;
        stopped = 1'b0;
        for (int c = 0; c < 2000 && !done && !stopped; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_word  = {$urandom, $urandom};
            chk("emit_out_valid", {63'h0, o_valid}, 64'h1);
            chk("emit_in_ready", {63'h0, o_in_ready}, 64'h0);
            chk("emit_busy", {63'h0, o_busy}, 64'h1);
            chk($sformatf("out_index_%0d", j), {57'h0, o_index}, 64'(j));
            chk($sformatf("out_word_W%0d", j), o_word, expw[j]);
            chk($sformatf("out_last_%0d", j), {63'h0, o_last}, {63'h0, j == rounds - 1});
            if (j == stop_at) begin
                out_ready = 1'b0;
                stopped = 1'b1;
            end else begin
                rdy = 1'b1;
                if (j == stall_at && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (rnd_ready) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
                out_ready = rdy;
                if (rdy) begin
                    got[j] = o_word;
                    j++;
                    if (j == rounds) done = 1'b1;
                end
            end
        end
        chk("drain_progress", {62'h0, done, stopped}, (stop_at >= 0) ? 64'h1 : 64'h2);
        if (done) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk("post_in_ready", {63'h0, o_in_ready}, 64'h1);
            chk("post_out_valid", {63'h0, o_valid}, 64'h0);
            chk("post_busy", {63'h0, o_busy}, 64'h0);
            chk("post_out_index", {57'h0, o_index}, 64'h0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = 64'h0;
        out_ready = 1'b0;
        abort     = 1'b0;
        select(1'b0);
        #1;
        chk("rst_in_ready32", {63'h0, in_ready32}, 64'h1);
        chk("rst_out_valid32", {63'h0, out_valid32}, 64'h0);
        chk("rst_out_last32", {63'h0, out_last32}, 64'h0);
        chk("rst_busy32", {63'h0, busy32}, 64'h0);
        chk("rst_out_word32", {32'h0, out_word32}, 64'h0);
        chk("rst_in_ready64", {63'h0, in_ready64}, 64'h1);
        chk("rst_out_word64", out_word64, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // SHA-256 "abc"
        set_abc();
        load(1'b0);
        drain(-1, 0, 1'b0, -1);
        chk("abc256_W0", got[0], 64'h61626380);
        chk("abc256_W16", got[16], 64'h61626380);
        chk("abc256_W17", got[17], 64'h000F0000);

        // Backpressure: 5-cycle stall at index 20
        set_rand();
        load(1'b0);
        drain(20, 5, 1'b0, -1);

        // Input gaps plus random output backpressure
        set_rand();
        load(1'b1);
        drain(-1, 0, 1'b1, -1);

        // Reset mid-EMIT at index 30
        set_abc();
        load(1'b0);
        drain(-1, 0, 1'b0, 30);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'h0, o_valid}, 64'h0);
        chk("midrst_in_ready", {63'h0, o_in_ready}, 64'h1);
        chk("midrst_busy", {63'h0, o_busy}, 64'h0);
        chk("midrst_out_index", {57'h0, o_index}, 64'h0);
        chk("midrst_out_word", o_word, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        load(1'b0);
        drain(-1, 0, 1'b0, -1);
        chk("reload_W17", got[17], 64'h000F0000);

        // SHA-512 "abc"
        select(1'b1);
        set_abc();
        load(1'b0);
        drain(-1, 0, 1'b0, -1);
        chk("abc512_W0", got[0], 64'h6162638000000000);
        chk("abc512_W16", got[16], 64'h6162638000000000);
        chk("abc512_W17", got[17], 64'h00030000000000C0);

        // SHA-512 random block with gaps and stalls
        set_rand();
        load(1'b1);
        drain(20, 5, 1'b1, -1);

`ifdef SHA2_SCHED_ABORT_EN
        select(1'b0);
        set_rand();
        load(1'b0);
        drain(-1, 0, 1'b0, 10);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_out_valid", {63'h0, o_valid}, 64'h0);
        chk("abort_in_ready", {63'h0, o_in_ready}, 64'h1);
        chk("abort_out_index", {57'h0, o_index}, 64'h0);
        set_abc();
        load(1'b0);
        drain(-1, 0, 1'b0, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
